wb_master_p: RTL and testbench

Parametrised Wishbone master bridge between the soft CPU's peripheral port and the on-chip Wishbone fabric. It converts a single CPU access (chip-select plus write-enable) into one Wishbone classic cycle. It has configurable data and address width, byte selects, a configurable timeout, error and retry termination, and a per-transaction response code. It replaces the fixed 8-bit bridge for peripherals that need 16- or 32-bit registers.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_tmo_cnt.sv | 35 +++
 rtl/wb_master_p.sv | 168 ++++++++++++++++
 tb/tb_wb_master_p.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the Wishbone masters: response codes and the
// bridge state encoding.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_DONE    = 2'd3
  } wb_state_e;

  localparam logic [1:0] RESP_ACK = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b01;
  localparam logic [1:0] RESP_TMO = 2'b10;
  localparam logic [1:0] RESP_RTY = 2'b11;

endpackage

// File: rtl/wb_tmo_cnt.sv
// Loadable down-counter with a zero flag; holds at zero. Used to bound
// how long a Wishbone strobe may stay high.
module wb_tmo_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/wb_master_p.sv
// Wishbone classic master bridge: turns one CPU access into one Wishbone
// cycle with timeout, error and bounded-retry termination.
module wb_master_p
  import wb_pkg::*;
#(
  parameter int              DW        = 8,
  parameter int              AW        = 8,
  parameter int              TIMEOUT   = 16,
  parameter int              MAX_RETRY = 2,
  parameter logic [DW-1:0]   FILL      = {DW/8{8'h55}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   din,
  input  logic [DW/8-1:0] sel,
  output logic [DW-1:0]   dout,
  output logic            rdy,
  output logic [1:0]      resp,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int CW = $clog2(TIMEOUT);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  wb_state_e       state_q, state_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d, dout_q, dout_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [1:0]      resp_q, resp_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            rdy_q, rdy_d;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            fin;
  logic [1:0]      fin_resp;

  wb_tmo_cnt #(.W(CW)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_LOAD),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    dout_d   = dout_q;
    resp_d   = resp_q;
    retry_d  = retry_q;
    rdy_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    fin      = 1'b0;
    fin_resp = RESP_ACK;
    unique case (state_q)
      ST_IDLE: begin
        if (cs) begin
          state_d  = ST_ACTIVE;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          we_d     = we;
          adr_d    = addr;
          sel_d    = sel;
          if (we) dat_d = din;
          cnt_load = 1'b1;
          retry_d  = '0;
        end
      end
      ST_ACTIVE: begin
        // Termination priority: ack > err > rty > timeout.
        if (wb_ack_i) begin
          fin = 1'b1; fin_resp = RESP_ACK;
        end else if (wb_err_i) begin
          fin = 1'b1; fin_resp = RESP_ERR;
        end else if (wb_rty_i && (retry_q < RETRY_MAX)) begin
          state_d = ST_BACKOFF;
          stb_d   = 1'b0;
          retry_d = retry_q + 1'b1;
        end else if (wb_rty_i) begin
          fin = 1'b1; fin_resp = RESP_RTY;
        end else if (cnt_zero) begin
          fin = 1'b1; fin_resp = RESP_TMO;
        end else begin
          cnt_dec = 1'b1;
        end
        if (fin) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rdy_d   = 1'b1;
          resp_d  = fin_resp;
          if (!we_q) dout_d = (fin_resp == RESP_ACK) ? wb_dat_i : FILL;
        end
      end
      ST_BACKOFF: begin
        state_d  = ST_ACTIVE;
        stb_d    = 1'b1;
        cnt_load = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      dout_q  <= FILL;
      resp_q  <= RESP_ACK;
      retry_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      resp_q  <= resp_d;
      retry_q <= retry_d;
      rdy_q   <= rdy_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign dout     = dout_q;
  assign resp     = resp_q;
  assign rdy      = rdy_q;

endmodule

// File: tb/tb_wb_master_p.sv
// Bench for wb_master_p (DW=32): a transaction-level model expands each
// slave response plan into the expected per-cycle bus trace.
module tb_wb_master_p;

  localparam int          TMO    = 16;
  localparam int          MRT    = 2;
  localparam logic [31:0] FILL_V = 32'h5555_5555;
  // slave plan kinds
  localparam int K_NONE = 0, K_ACK = 1, K_ERR = 2, K_RTY = 3, K_ACKERR = 4;

  logic        clk = 1'b0;
  logic        rst_n, cs, we, rdy;
  logic [7:0]  addr;
  logic [31:0] din, dout, wb_dat_o, wb_dat_i;
  logic [3:0]  sel, wb_sel_o;
  logic [1:0]  resp;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [7:0]  wb_adr_o;

  wb_master_p #(.DW(32), .AW(8), .TIMEOUT(TMO), .MAX_RETRY(MRT)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din), .sel(sel),
    .dout(dout), .rdy(rdy), .resp(resp),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cyc, stb, rdy;
    logic [1:0] resp;
    logic [31:0] dout;
    logic we;
    logic [7:0] adr;
    logic [31:0] dat;
    logic [3:0] sel;
  } ent_t;

  ent_t exq[$];
  int   n_tests = 0, n_fail = 0;
  logic chk_en = 1'b0, noise = 1'b0;
  int   plan_k[4], plan_w[4];
  int   sn, gn, rk, s2;

  logic [1:0]  m_resp;
  logic [31:0] m_dout, m_dat;
  logic        m_we;
  logic [7:0]  m_adr;
  logic [3:0]  m_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t idle_ent();
    ent_t e;
    e.cyc = 1'b0; e.stb = 1'b0; e.rdy = 1'b0;
    e.resp = m_resp; e.dout = m_dout;
    e.we = m_we; e.adr = m_adr; e.dat = m_dat; e.sel = m_sel;
    return e;
  endfunction

  function automatic void model_reset();
    m_resp = 2'b00; m_dout = FILL_V; m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
  endfunction

  function automatic void set_plan(input int k0, input int w0, input int k1, input int w1,
                                   input int k2, input int w2);
    plan_k[0] = k0; plan_w[0] = w0; plan_k[1] = k1; plan_w[1] = w1;
    plan_k[2] = k2; plan_w[2] = w2; plan_k[3] = K_NONE; plan_w[3] = 0;
  endfunction

  // Expand one access into its expected cycle-by-cycle trace.
  function automatic void model_push(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                     input logic [3:0] s, input logic [31:0] rd);
    int   len, outc;
    ent_t e;
    m_we = wr; m_adr = a; m_sel = s;
    if (wr) m_dat = d;
    for (int at = 0; at <= MRT; at++) begin
      if (plan_k[at] != K_NONE && plan_w[at] < TMO) begin
        len = plan_w[at] + 1; outc = plan_k[at];
      end else begin
        len = TMO; outc = K_NONE;
      end
      e = idle_ent(); e.cyc = 1'b1; e.stb = 1'b1;
      for (int i = 0; i < len; i++) exq.push_back(e);
      if (outc == K_RTY && at < MRT) begin
        e.stb = 1'b0;
        exq.push_back(e);
        continue;
      end
      case (outc)
        K_ACK, K_ACKERR: begin m_resp = 2'b00; if (!wr) m_dout = rd; end
        K_ERR:           m_resp = 2'b01;
        K_RTY:           m_resp = 2'b11;
        default:         m_resp = 2'b10;
      endcase
      if (!wr && !(outc == K_ACK || outc == K_ACKERR)) m_dout = FILL_V;
      e = idle_ent(); e.rdy = 1'b1;
      exq.push_back(e);
      break;
    end
  endfunction

  // Per-cycle compare against the model trace (idle expectation when empty).
  always @(negedge clk) begin
    ent_t e;
    if (chk_en) begin
      if (exq.size() > 0) e = exq.pop_front();
      else e = idle_ent();
      chk("cyc_stb_rdy", 32'({wb_cyc_o, wb_stb_o, rdy}), 32'({e.cyc, e.stb, e.rdy}));
      chk("resp", 32'(resp), 32'(e.resp));
      chk("dout", dout, e.dout);
      chk("we_adr_sel", 32'({wb_we_o, wb_adr_o, wb_sel_o}), 32'({e.we, e.adr, e.sel}));
      chk("wb_dat_o", wb_dat_o, e.dat);
    end
  end

  // Issue nrep accesses (cs held between them) and act as the slave.
  task automatic run_txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] rd, input int nrep,
                         output int stb_n, output int gap_n, output int rdy_k, output int stb2_k);
    int k, acc, rdys, att, c;
    logic pstb, pcyc;
    stb_n = 0; gap_n = 0; rdy_k = -1; stb2_k = -1;
    k = 0; acc = 0; rdys = 0; att = -1; c = 0; pstb = 1'b0; pcyc = 1'b0;
    for (int r = 0; r < nrep; r++) begin
      model_push(wr, a, d, s, rd);
      if (r < nrep - 1) exq.push_back(idle_ent());
    end
    cs = 1'b1; we = wr; addr = a; din = d; sel = s; wb_dat_i = rd;
    while (rdys < nrep && k < 200) begin
      @(negedge clk); #1;
      k++;
      if (wb_cyc_o && !pcyc) begin acc++; att = -1; end
      if (acc >= nrep) cs = 1'b0;
      if (wb_stb_o) begin
        stb_n++;
        if (!pstb) begin
          att++; c = 0;
          if (acc == 2 && stb2_k < 0) stb2_k = k;
        end else c++;
      end else if (wb_cyc_o) gap_n++;
      if (rdy) begin rdys++; if (rdy_k < 0) rdy_k = k; end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (wb_stb_o) begin
        if (att >= 0 && att < 4 && c == plan_w[att]) begin
          case (plan_k[att])
            K_ACK:    wb_ack_i = 1'b1;
            K_ERR:    wb_err_i = 1'b1;
            K_RTY:    wb_rty_i = 1'b1;
            K_ACKERR: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
            default:  ;
          endcase
        end
      end else if (noise) begin
        {wb_ack_i, wb_err_i, wb_rty_i} = 3'($urandom);
      end
      pstb = wb_stb_o; pcyc = wb_cyc_o;
    end
    chk("txn_completed", 32'(rdys), 32'(nrep));
    if (rdys < nrep) exq.delete();
    cs = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rw;
    logic [7:0] ra;
    logic [31:0] rd, rdat;
    logic [3:0] rs;
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0; sel = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
    model_reset();
    set_plan(K_ACK, 0, K_NONE, 0, K_NONE, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", 32'({wb_cyc_o, wb_stb_o, rdy}), 32'h0);
    chk("reset_dout", dout, 32'h5555_5555);
    chk("reset_resp", 32'(resp), 32'h0);
    chk("reset_bus", 32'({wb_we_o, wb_adr_o, wb_sel_o}) | wb_dat_o, 32'h0);
    rst_n = 1'b1; chk_en = 1'b1;
    @(negedge clk); #1;

    // write, zero-wait ack
    set_plan(K_ACK, 0, K_NONE, 0, K_NONE, 0);
    run_txn(1'b1, 8'h12, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1, sn, gn, rk, s2);
    chk("wr_stb_cycles", sn, 1);
    chk("wr_rdy_latency", rk, 2);
    chk("wr_resp", 32'(resp), 32'h0);
    chk("wr_dat", wb_dat_o, 32'hDEAD_BEEF);
    chk("wr_sel", 32'(wb_sel_o), 32'h3);

    // read, ack after 5 wait cycles
    set_plan(K_ACK, 5, K_NONE, 0, K_NONE, 0);
    run_txn(1'b0, 8'h34, 32'h0, 4'b0001, 32'h0000_00A5, 1, sn, gn, rk, s2);
    chk("rd_stb_cycles", sn, 6);
    chk("rd_dout", dout, 32'h0000_00A5);
    chk("rd_resp", 32'(resp), 32'h0);

    // timeout
    set_plan(K_NONE, 0, K_NONE, 0, K_NONE, 0);
    run_txn(1'b0, 8'h40, 32'h0, 4'b1111, 32'h1111_2222, 1, sn, gn, rk, s2);
    chk("tmo_stb_cycles", sn, 16);
    chk("tmo_resp", 32'(resp), 32'h2);
    chk("tmo_dout", dout, 32'h5555_5555);

    // ack on the last counter cycle
    set_plan(K_ACK, 15, K_NONE, 0, K_NONE, 0);
    run_txn(1'b0, 8'h41, 32'h0, 4'b1111, 32'h1234_5678, 1, sn, gn, rk, s2);
    chk("lastack_stb_cycles", sn, 16);
    chk("lastack_resp", 32'(resp), 32'h0);
    chk("lastack_dout", dout, 32'h1234_5678);

    // two retries then ack
    set_plan(K_RTY, 1, K_RTY, 0, K_ACK, 3);
    run_txn(1'b1, 8'h50, 32'hCAFE_F00D, 4'b1100, 32'h0, 1, sn, gn, rk, s2);
    chk("rty_gaps", gn, 2);
    chk("rty_stb_cycles", sn, 7);
    chk("rty_resp", 32'(resp), 32'h0);

    // retries exhausted
    set_plan(K_RTY, 0, K_RTY, 0, K_RTY, 0);
    run_txn(1'b0, 8'h51, 32'h0, 4'b1111, 32'h9999_9999, 1, sn, gn, rk, s2);
    chk("rtyx_gaps", gn, 2);
    chk("rtyx_resp", 32'(resp), 32'h3);
    chk("rtyx_dout", dout, 32'h5555_5555);

    // ack and err together, then err alone on a write
    set_plan(K_ACKERR, 0, K_NONE, 0, K_NONE, 0);
    run_txn(1'b0, 8'h60, 32'h0, 4'b0001, 32'h0000_00A5, 1, sn, gn, rk, s2);
    chk("ackerr_resp", 32'(resp), 32'h0);
    chk("ackerr_dout", dout, 32'h0000_00A5);
    set_plan(K_ERR, 2, K_NONE, 0, K_NONE, 0);
    run_txn(1'b1, 8'h61, 32'h0BAD_0BAD, 4'b1111, 32'h0, 1, sn, gn, rk, s2);
    chk("err_resp", 32'(resp), 32'h1);
    chk("err_wr_keeps_dout", dout, 32'h0000_00A5);

    // reset in the middle of an ACTIVE cycle
    chk_en = 1'b0;
    set_plan(K_NONE, 0, K_NONE, 0, K_NONE, 0);
    cs = 1'b1; we = 1'b0; addr = 8'h70;
    @(negedge clk); #1;
    cs = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midrst_cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'h0);
    chk("midrst_dout", dout, 32'h5555_5555);
    chk("midrst_resp", 32'(resp), 32'h0);
    chk("midrst_rdy", 32'(rdy), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    exq.delete();
    model_reset();
    chk_en = 1'b1;
    repeat (20) @(negedge clk);
    #1;

    // back-to-back with cs held
    set_plan(K_ACK, 0, K_NONE, 0, K_NONE, 0);
    run_txn(1'b1, 8'h80, 32'h0102_0304, 4'b1111, 32'h0, 2, sn, gn, rk, s2);
    chk("b2b_idle_cycles", s2 - rk - 1, 1);

    // randomized accesses with termination noise outside strobe
    noise = 1'b1;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 4; i++) begin
        plan_k[i] = $urandom_range(0, 4);
        plan_w[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4);
      end
      rw = 1'($urandom); ra = 8'($urandom); rd = $urandom; rdat = $urandom; rs = 4'($urandom);
      run_txn(rw, ra, rd, rs, rdat, ($urandom_range(0, 4) == 0) ? 2 : 1, sn, gn, rk, s2);
    end
    noise = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
